// File: rtl/cpu_mem_arbiter_if.sv
// Bus bundle between the CPU-side requesters, the memory port unit and the
// pipelined memory bus. The slave modport is the arbiter's view.
interface cpu_mem_arbiter_if #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 16,
  parameter int MAX_OUTST = 4
);
  localparam int CNT_W = $clog2(MAX_OUTST + 1);

  logic              i_if_req;
  logic [ADDR_W-1:0] i_if_addr;
  logic              o_if_gnt;
  logic              o_if_rdvalid;
  logic [DATA_W-1:0] o_if_rddata;

  logic              i_d_req;
  logic              i_d_wr;
  logic [ADDR_W-1:0] i_d_addr;
  logic [DATA_W-1:0] i_d_wrdata;
  logic              o_d_gnt;
  logic              o_d_rdvalid;
  logic [DATA_W-1:0] o_d_rddata;

  logic [ADDR_W-1:0] o_mem_addr;
  logic              o_mem_rd;
  logic              o_mem_wr;
  logic [DATA_W-1:0] o_mem_wrdata;
  logic              i_mem_wait;
  logic [DATA_W-1:0] i_mem_rddata;
  logic              i_mem_rddatavalid;

  logic [CNT_W-1:0]  o_outst_cnt;
  logic              o_err;

  modport slave (
    input  i_if_req, i_if_addr,
    output o_if_gnt, o_if_rdvalid, o_if_rddata,
    input  i_d_req, i_d_wr, i_d_addr, i_d_wrdata,
    output o_d_gnt, o_d_rdvalid, o_d_rddata,
    output o_mem_addr, o_mem_rd, o_mem_wr, o_mem_wrdata,
    input  i_mem_wait, i_mem_rddata, i_mem_rddatavalid,
    output o_outst_cnt, o_err
  );

  modport master (
    output i_if_req, i_if_addr,
    input  o_if_gnt, o_if_rdvalid, o_if_rddata,
    output i_d_req, i_d_wr, i_d_addr, i_d_wrdata,
    input  o_d_gnt, o_d_rdvalid, o_d_rddata,
    input  o_mem_addr, o_mem_rd, o_mem_wr, o_mem_wrdata,
    output i_mem_wait, i_mem_rddata, i_mem_rddatavalid,
    input  o_outst_cnt, o_err
  );
endinterface

// File: rtl/cpu_mem_arbiter.sv
// Shared memory port for instruction fetch and data accesses. Data has fixed
// priority over fetch; up to MAX_OUTST reads may be in flight, and a tag FIFO
// routes each in-order return back to the channel that issued it.
//
// state     | meaning
// ----------+---------------------------------------------------------
// CMD_EMPTY | command register holds nothing, free to capture
// CMD_FULL  | command presented on the bus, free once i_mem_wait is low
module cpu_mem_arbiter #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 16,
  parameter int MAX_OUTST = 4
) (
  input logic         clk,
  input logic         reset,
  cpu_mem_arbiter_if.slave bus
);
  localparam int CNT_W = $clog2(MAX_OUTST + 1);
  localparam int PTR_W = $clog2(MAX_OUTST);

  typedef enum logic {CMD_EMPTY, CMD_FULL} cmd_state_t;

  cmd_state_t        state_q, state_d;
  logic              cmd_rd_q, cmd_wr_q;
  logic [ADDR_W-1:0] cmd_addr_q;
  logic [DATA_W-1:0] cmd_wrdata_q;

  logic [MAX_OUTST-1:0] tag_mem_q;
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 err_q;

  logic              if_rdvalid_q, d_rdvalid_q;
  logic [DATA_W-1:0] if_rddata_q, d_rddata_q;

  logic cmd_free, room, d_gnt, if_gnt;
  logic rd_capture, ret_pop, ret_err, pop_tag;

  // Command register occupancy: present next state from capture/accept.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= CMD_EMPTY;
    else        state_q <= state_d;
  end

  // Arbitration and next-state; grants are suppressed while reset is asserted
  // so every output reads 0 during reset.
  always_comb begin
    state_d  = state_q;
    d_gnt    = 1'b0;
    if_gnt   = 1'b0;
    cmd_free = (state_q == CMD_EMPTY) || !bus.i_mem_wait;
    room     = cnt_q < CNT_W'(MAX_OUTST);
    if (reset && cmd_free) begin
      if (bus.i_d_req)       d_gnt  = bus.i_d_wr || room;
      else if (bus.i_if_req) if_gnt = room;
    end
    if (d_gnt || if_gnt) state_d = CMD_FULL;
    else if (cmd_free)   state_d = CMD_EMPTY;
  end

  // A blocked data read also blocks fetch because fetch only wins when no
  // data request is pending at all.
  assign rd_capture = if_gnt || (d_gnt && !bus.i_d_wr);
  assign ret_pop    = bus.i_mem_rddatavalid && (cnt_q != '0);
  assign ret_err    = bus.i_mem_rddatavalid && (cnt_q == '0);
  assign pop_tag    = tag_mem_q[rd_ptr_q];

  // Command register: load on capture, drop rd/wr once accepted with nothing new.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cmd_rd_q     <= 1'b0;
      cmd_wr_q     <= 1'b0;
      cmd_addr_q   <= '0;
      cmd_wrdata_q <= '0;
    end else if (d_gnt) begin
      cmd_rd_q     <= !bus.i_d_wr;
      cmd_wr_q     <= bus.i_d_wr;
      cmd_addr_q   <= bus.i_d_addr;
      cmd_wrdata_q <= bus.i_d_wrdata;
    end else if (if_gnt) begin
      cmd_rd_q   <= 1'b1;
      cmd_wr_q   <= 1'b0;
      cmd_addr_q <= bus.i_if_addr;
    end else if (cmd_free) begin
      cmd_rd_q <= 1'b0;
      cmd_wr_q <= 1'b0;
    end
  end

  // Tag FIFO: 0 = fetch, 1 = data; pointers wrap since depth is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag_mem_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
    end else begin
      if (rd_capture) begin
        tag_mem_q[wr_ptr_q] <= d_gnt;
        wr_ptr_q            <= wr_ptr_q + PTR_W'(1);
      end
      if (ret_pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  // Outstanding read counter; capture and return together cancel out.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else if (rd_capture && !ret_pop) cnt_q <= cnt_q + CNT_W'(1);
    else if (!rd_capture && ret_pop) cnt_q <= cnt_q - CNT_W'(1);
  end

  // Registered return steering; rddata holds until the next return to its channel.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      if_rdvalid_q <= 1'b0;
      d_rdvalid_q  <= 1'b0;
      if_rddata_q  <= '0;
      d_rddata_q   <= '0;
    end else begin
      if_rdvalid_q <= ret_pop && !pop_tag;
      d_rdvalid_q  <= ret_pop && pop_tag;
      if (ret_pop && !pop_tag) if_rddata_q <= bus.i_mem_rddata;
      if (ret_pop && pop_tag)  d_rddata_q  <= bus.i_mem_rddata;
    end
  end

  // Sticky error for a return with nothing in flight; data is dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       err_q <= 1'b0;
    else if (ret_err) err_q <= 1'b1;
  end

  assign bus.o_if_gnt     = if_gnt;
  assign bus.o_d_gnt      = d_gnt;
  assign bus.o_if_rdvalid = if_rdvalid_q;
  assign bus.o_if_rddata  = if_rddata_q;
  assign bus.o_d_rdvalid  = d_rdvalid_q;
  assign bus.o_d_rddata   = d_rddata_q;
  assign bus.o_mem_addr   = cmd_addr_q;
  assign bus.o_mem_rd     = cmd_rd_q;
  assign bus.o_mem_wr     = cmd_wr_q;
  assign bus.o_mem_wrdata = cmd_wrdata_q;
  assign bus.o_outst_cnt  = cnt_q;
  assign bus.o_err        = err_q;
endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Bench for cpu_mem_arbiter: directed scenarios followed by random traffic,
// with a queue-based reference model compared on every falling edge.
module tb_cpu_mem_arbiter;
  localparam int DW = 16;
  localparam int AW = 16;
  localparam int MO = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  cpu_mem_arbiter_if #(.DATA_W(DW), .ADDR_W(AW), .MAX_OUTST(MO)) bus ();
  cpu_mem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MAX_OUTST(MO)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int n_chk = 0;
  int n_pass = 0;
  int pending_ret = 0;

  // Reference model: pending command, queue of read owners, return outputs.
  bit          m_pv = 0, m_rd = 0, m_wr = 0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0;
  bit          tagq[$];
  bit          m_ifv = 0, m_dv = 0, m_err = 0;
  logic [DW-1:0] m_ifd = '0, m_dd = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  function automatic void exp_gnt(output bit eif, output bit ed);
    bit free, room;
    free = !m_pv || !bus.i_mem_wait;
    room = tagq.size() < MO;
    ed   = reset && free && bus.i_d_req && (bus.i_d_wr || room);
    eif  = reset && free && bus.i_if_req && !bus.i_d_req && room;
  endfunction

  always @(posedge clk or negedge reset) begin : model
    bit eif, ed, t;
    if (!reset) begin
      m_pv = 0; m_rd = 0; m_wr = 0; m_addr = '0; m_wdata = '0;
      tagq.delete();
      m_ifv = 0; m_dv = 0; m_ifd = '0; m_dd = '0; m_err = 0;
    end else begin
      exp_gnt(eif, ed);
      m_ifv = 0;
      m_dv  = 0;
      if (bus.i_mem_rddatavalid) begin
        if (tagq.size() == 0) m_err = 1;
        else begin
          t = tagq.pop_front();
          if (t) begin m_dv = 1; m_dd = bus.i_mem_rddata; end
          else begin m_ifv = 1; m_ifd = bus.i_mem_rddata; end
        end
      end
      if (ed) begin
        m_pv = 1; m_rd = !bus.i_d_wr; m_wr = bus.i_d_wr;
        m_addr = bus.i_d_addr; m_wdata = bus.i_d_wrdata;
        if (!bus.i_d_wr) tagq.push_back(1'b1);
      end else if (eif) begin
        m_pv = 1; m_rd = 1; m_wr = 0; m_addr = bus.i_if_addr;
        tagq.push_back(1'b0);
      end else if (!m_pv || !bus.i_mem_wait) begin
        m_pv = 0; m_rd = 0; m_wr = 0;
      end
    end
  end

  // Memory side bookkeeping: reads accepted but not yet answered.
  always @(posedge clk) begin
    if (bus.o_mem_rd && !bus.i_mem_wait) pending_ret++;
    if (bus.i_mem_rddatavalid && pending_ret > 0) pending_ret--;
  end

  always @(negedge clk) begin : compare
    bit eif, ed;
    exp_gnt(eif, ed);
    chk("if_gnt", bus.o_if_gnt, eif);
    chk("d_gnt", bus.o_d_gnt, ed);
    chk("mem_rd", bus.o_mem_rd, m_rd);
    chk("mem_wr", bus.o_mem_wr, m_wr);
    chk("mem_addr", bus.o_mem_addr, m_addr);
    if (m_wr) chk("mem_wrdata", bus.o_mem_wrdata, m_wdata);
    chk("if_rdvalid", bus.o_if_rdvalid, m_ifv);
    chk("if_rddata", bus.o_if_rddata, m_ifd);
    chk("d_rdvalid", bus.o_d_rdvalid, m_dv);
    chk("d_rddata", bus.o_d_rddata, m_dd);
    chk("outst_cnt", bus.o_outst_cnt, 32'(tagq.size()));
    chk("err", bus.o_err, m_err);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.i_if_req = 0; bus.i_d_req = 0; bus.i_d_wr = 0;
    bus.i_mem_wait = 0; bus.i_mem_rddatavalid = 0;
  endtask

  task automatic drain();
    for (int i = 0; i < 30; i++) begin
      bus.i_mem_rddatavalid = (pending_ret > 0);
      bus.i_mem_rddata = DW'($urandom);
      cyc();
    end
    bus.i_mem_rddatavalid = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit gi, gd;
    bus.i_if_addr = '0; bus.i_d_addr = '0; bus.i_d_wrdata = '0; bus.i_mem_rddata = '0;
    idle_inputs();
    repeat (3) cyc();
    chk("rst_cnt", bus.o_outst_cnt, 0);
    chk("rst_memrd", bus.o_mem_rd, 0);
    chk("rst_err", bus.o_err, 0);
    reset = 1;
    cyc();

    // Single fetch
    bus.i_if_req = 1; bus.i_if_addr = 16'h0040;
    #1 chk("t1_gnt", bus.o_if_gnt, 1);
    cyc(); bus.i_if_req = 0;
    chk("t1_memrd", bus.o_mem_rd, 1);
    chk("t1_addr", bus.o_mem_addr, 16'h0040);
    cyc();
    cyc(); bus.i_mem_rddatavalid = 1; bus.i_mem_rddata = 16'hBEEF;
    cyc(); bus.i_mem_rddatavalid = 0;
    chk("t1_rdv", bus.o_if_rdvalid, 1);
    chk("t1_data", bus.o_if_rddata, 16'hBEEF);
    chk("t1_drdv", bus.o_d_rdvalid, 0);
    cyc();
    chk("t1_hold", bus.o_if_rddata, 16'hBEEF);

    // Wait hold
    bus.i_d_req = 1; bus.i_d_wr = 1; bus.i_d_addr = 16'h0100; bus.i_d_wrdata = 16'h1234;
    #1 chk("t2_gnt", bus.o_d_gnt, 1);
    cyc(); bus.i_d_req = 0; bus.i_d_wr = 0; bus.i_mem_wait = 1;
    bus.i_if_req = 1; bus.i_if_addr = 16'h0010;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t2_wr", bus.o_mem_wr, 1);
      chk("t2_addr", bus.o_mem_addr, 16'h0100);
      chk("t2_wdata", bus.o_mem_wrdata, 16'h1234);
      chk("t2_nognt", bus.o_if_gnt, 0);
      cyc();
    end
    bus.i_mem_wait = 0;
    #1;
    chk("t2_wr4", bus.o_mem_wr, 1);
    chk("t2_accgnt", bus.o_if_gnt, 1);
    cyc(); bus.i_if_req = 0;
    drain();

    // Priority and routing
    bus.i_d_req = 1; bus.i_d_wr = 0; bus.i_d_addr = 16'h0200;
    bus.i_if_req = 1; bus.i_if_addr = 16'h0010;
    #1;
    chk("t3_dgnt", bus.o_d_gnt, 1);
    chk("t3_ifwait", bus.o_if_gnt, 0);
    cyc(); bus.i_d_req = 0;
    #1;
    chk("t3_ifgnt", bus.o_if_gnt, 1);
    chk("t3_addr_d", bus.o_mem_addr, 16'h0200);
    cyc(); bus.i_if_req = 0;
    chk("t3_addr_if", bus.o_mem_addr, 16'h0010);
    bus.i_mem_rddatavalid = 1; bus.i_mem_rddata = 16'hAAAA;
    cyc(); bus.i_mem_rddata = 16'hBBBB;
    chk("t3_drdv", bus.o_d_rdvalid, 1);
    chk("t3_ddata", bus.o_d_rddata, 16'hAAAA);
    cyc(); bus.i_mem_rddatavalid = 0;
    chk("t3_ifrdv", bus.o_if_rdvalid, 1);
    chk("t3_ifdata", bus.o_if_rddata, 16'hBBBB);
    cyc();
    chk("t3_cnt", bus.o_outst_cnt, 0);

    // Full limit
    for (int i = 0; i < 4; i++) begin
      bus.i_if_req = 1; bus.i_if_addr = AW'(16'h0300 + i);
      #1 chk("t4_gnt", bus.o_if_gnt, 1);
      cyc();
    end
    bus.i_if_addr = 16'h0304;
    #1;
    chk("t4_stall", bus.o_if_gnt, 0);
    chk("t4_cnt", bus.o_outst_cnt, 4);
    cyc();
    bus.i_d_req = 1; bus.i_d_wr = 1; bus.i_d_addr = 16'h0400; bus.i_d_wrdata = 16'h5555;
    #1;
    chk("t4_wrgnt", bus.o_d_gnt, 1);
    chk("t4_stall2", bus.o_if_gnt, 0);
    cyc(); bus.i_d_req = 0; bus.i_d_wr = 0;
    #1 chk("t4_stall3", bus.o_if_gnt, 0);
    cyc(); bus.i_mem_rddatavalid = 1; bus.i_mem_rddata = 16'h0123;
    #1 chk("t4_retcyc", bus.o_if_gnt, 0);
    cyc(); bus.i_mem_rddatavalid = 0;
    #1 chk("t4_release", bus.o_if_gnt, 1);
    cyc(); bus.i_if_req = 0;
    drain();
    chk("t4_cnt0", bus.o_outst_cnt, 0);

    // Protocol error
    bus.i_mem_rddatavalid = 1; bus.i_mem_rddata = 16'h7777;
    cyc(); bus.i_mem_rddatavalid = 0;
    chk("t5_err", bus.o_err, 1);
    chk("t5_ifrdv", bus.o_if_rdvalid, 0);
    chk("t5_drdv", bus.o_d_rdvalid, 0);
    repeat (3) cyc();
    chk("t5_sticky", bus.o_err, 1);
    reset = 0;
    cyc();
    reset = 1;
    cyc();
    chk("t5_clr", bus.o_err, 0);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      gi = bus.o_if_gnt;
      gd = bus.o_d_gnt;
      @(posedge clk);
      #1;
      if (!bus.i_if_req || gi) begin
        bus.i_if_req = ($urandom_range(0, 2) != 0);
        bus.i_if_addr = AW'($urandom);
      end
      if (!bus.i_d_req || gd) begin
        bus.i_d_req = ($urandom_range(0, 2) == 0);
        bus.i_d_wr = 1'($urandom_range(0, 1));
        bus.i_d_addr = AW'($urandom);
        bus.i_d_wrdata = DW'($urandom);
      end
      bus.i_mem_wait = ($urandom_range(0, 3) == 0);
      bus.i_mem_rddatavalid = (pending_ret > 0) && ($urandom_range(0, 1) == 1);
      bus.i_mem_rddata = DW'($urandom);
    end
    cyc();
    idle_inputs();
    drain();
    chk("rnd_cnt0", bus.o_outst_cnt, 0);
    chk("rnd_err", bus.o_err, 0);

    // Reset mid-operation
    bus.i_if_req = 1; bus.i_if_addr = 16'h0500;
    cyc(); bus.i_if_addr = 16'h0501;
    cyc(); bus.i_if_req = 0;
    bus.i_d_req = 1; bus.i_d_wr = 1; bus.i_d_addr = 16'h0600; bus.i_d_wrdata = 16'h9999;
    #1 chk("t6_wgnt", bus.o_d_gnt, 1);
    cyc(); bus.i_d_req = 0; bus.i_d_wr = 0; bus.i_mem_wait = 1;
    cyc();
    chk("t6_held", bus.o_mem_wr, 1);
    chk("t6_cnt2", bus.o_outst_cnt, 2);
    bus.i_d_req = 1; bus.i_d_wr = 1;
    #2 reset = 0;
    #1;
    chk("t6_wr0", bus.o_mem_wr, 0);
    chk("t6_rd0", bus.o_mem_rd, 0);
    chk("t6_addr0", bus.o_mem_addr, 0);
    chk("t6_wdata0", bus.o_mem_wrdata, 0);
    chk("t6_cnt0", bus.o_outst_cnt, 0);
    chk("t6_dgnt0", bus.o_d_gnt, 0);
    idle_inputs();
    cyc();
    cyc();
    reset = 1;
    cyc(); bus.i_mem_rddatavalid = (pending_ret > 0); bus.i_mem_rddata = 16'h4444;
    cyc(); bus.i_mem_rddatavalid = (pending_ret > 0);
    cyc(); bus.i_mem_rddatavalid = 0;
    chk("t6_err", bus.o_err, 1);
    chk("t6_ifrdv", bus.o_if_rdvalid, 0);
    cyc();
    chk("t6_err2", bus.o_err, 1);
    chk("t6_drdv", bus.o_d_rdvalid, 0);
    repeat (2) cyc();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
